// File: rtl/booth_radix4_ctrl.sv
// booth_radix4_ctrl
// Sequencer and Booth-recoding stage for an 8-bit signed radix-4 multiplier.
// It drives a shift-by-2 partial-product accumulator that sits downstream.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous reset, active low
//   start    : multiply request, sampled only while idle
//   mcand    : signed multiplicand, latched when start is accepted
//   mplier   : signed multiplier, latched when start is accepted
//   acc_res  : 16-bit result from the accumulator
//   md       : 9-bit recoded partial-product operand (combinational from state)
//   cla_sub  : +1 carry-in that completes a negative digit (combinational)
//   load     : accumulator clear, high for the CLEAR cycle (combinational)
//   busy     : high while a multiply is in flight
//   done     : one-cycle pulse, product valid
//   product  : signed product, held until the next capture
module booth_radix4_ctrl (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7:0]              mcand,
   input  logic [7:0]              mplier,
   input  logic [15:0]             acc_res,
   output logic [8:0]              md,
   output logic                    cla_sub,
   output logic                    load,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             product
);

   localparam int unsigned OP_W   = 8;
   localparam int unsigned MD_W   = OP_W + 1;
   localparam int unsigned RES_W  = 2 * OP_W;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_ADD     = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    m_q, m_d;
   logic [MD_W-1:0]    q_q, q_d;      // {mplier, 1'b0}: bit 0 is Booth bit -1
   logic [RES_W-1:0]   product_q, product_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [2:0]         triplet;
   logic [MD_W-1:0]    mx;
   logic [MD_W-1:0]    m2;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         m_q       <= '0;
         q_q       <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         m_q       <= m_d;
         q_q       <= q_d;
         product_q <= product_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic; operands are only captured on acceptance in IDLE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      m_d       = m_q;
      q_d       = q_q;
      product_d = product_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = mcand;
               q_d     = {mplier, 1'b0};
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(3)) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            product_d = acc_res;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Overlapping Booth triplet for the current digit
   always_comb begin
      triplet = 3'b000;
      unique case (cnt_q)
         2'd0: triplet = q_q[2:0];
         2'd1: triplet = q_q[4:2];
         2'd2: triplet = q_q[6:4];
         2'd3: triplet = q_q[8:6];
         default: triplet = 3'b000;
      endcase
   end

   assign mx = {m_q[OP_W-1], m_q};
   assign m2 = {m_q, 1'b0};

   // Accumulator controls decode from registered state only; negative digits
   // are ones' complement with cla_sub supplying the +1
   always_comb begin
      md      = '0;
      cla_sub = 1'b0;
      load    = 1'b0;
      if (state_q == S_CLEAR) begin
         load = 1'b1;
      end else if (state_q == S_ADD) begin
         unique case (triplet)
            3'b001, 3'b010: md = mx;
            3'b011:         md = m2;
            3'b100: begin
               md      = ~m2;
               cla_sub = 1'b1;
            end
            3'b101, 3'b110: begin
               md      = ~mx;
               cla_sub = 1'b1;
            end
            default: md = '0;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_ctrl.sv
// Testbench for booth_radix4_ctrl with a behavioural shift-by-2 accumulator.
// Expected products and digit operands are queued by the stimulus; a monitor
// compares them against what the DUT presents.
module tb_booth_radix4_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  mcand;
   logic [7:0]  mplier;
   logic [15:0] acc_res;
   logic [8:0]  md;
   logic        cla_sub;
   logic        load;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt = 0;

   logic [15:0] eq[$];   // expected products
   logic [9:0]  dq[$];   // expected {md, cla_sub} per digit

   booth_radix4_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mcand   (mcand),
      .mplier  (mplier),
      .acc_res (acc_res),
      .md      (md),
      .cla_sub (cla_sub),
      .load    (load),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator: clear on load, then add four digits weighted by 4^k
   logic signed [15:0] acc;
   logic signed [15:0] pp;
   int unsigned        w;
   assign pp      = 16'($signed(md)) + {15'b0, cla_sub};
   assign acc_res = acc;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         w   <= 4;
      end else if (load) begin
         acc <= '0;
         w   <= 0;
      end else if (w < 4) begin
         acc <= acc + (pp <<< (2 * w));
         w   <= w + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: product scoreboard on done, digit scoreboard after load
   logic load_prev = 1'b0;
   int   dig_left  = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            done_cnt++;
            chk("busy_low_with_done", 32'(busy), 32'd0);
            if (eq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else chk("product", 32'(product), 32'(eq.pop_front()));
         end
         if (load && load_prev) chk("load_one_cycle", 32'(load_prev), 32'd0);
         if (dig_left > 0) begin
            if (dq.size() > 0) chk("digit_md_sub", {22'b0, md, cla_sub}, {22'b0, dq.pop_front()});
            dig_left--;
         end
         if (load) dig_left = 4;
         load_prev = load;
      end else begin
         load_prev = 1'b0;
         dig_left  = 0;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit chk_lat);
      logic signed [15:0] e;
      int n;
      bit got;
      @(negedge clk);
      wait_idle();
      e = $signed(a) * $signed(b);
      eq.push_back(e);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      mcand  = 8'($urandom);
      mplier = 8'($urandom);
      n   = 0;
      got = 1'b0;
      while (n < 12 && !got) begin
         @(posedge clk);
         n++;
         #1 got = done;
      end
      if (chk_lat) chk("done_latency", 32'(n), 32'd6);
      else chk("done_seen", 32'(got), 32'd1);
   endtask

   logic [7:0] ba[4];
   logic [7:0] bb[4];

   initial begin
      int saved;
      rst    = 1'b0;
      start  = 1'b0;
      mcand  = '0;
      mplier = '0;
      #3;
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_load",    32'(load),    32'd0);
      chk("rst_md",      {22'b0, md, cla_sub}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Digit sequence 3 x 127
      dq.push_back({9'h1FC, 1'b1});
      dq.push_back({9'h000, 1'b0});
      dq.push_back({9'h000, 1'b0});
      dq.push_back({9'h006, 1'b0});
      do_mul(8'd3, 8'd127, 1'b1);
      @(negedge clk);
      chk("digits_consumed", 32'(dq.size()), 32'd0);
      chk("product_381", 32'(product), 32'h017D);

      // Reset in the middle of ADD aborts with no done
      start = 1'b1; mcand = 8'd7; mplier = 8'd9;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_product", 32'(product), 32'd0);
      chk("midrst_busy",    32'(busy),    32'd0);
      chk("midrst_done",    32'(done),    32'd0);
      chk("midrst_load",    32'(load),    32'd0);
      chk("midrst_md",      {22'b0, md, cla_sub}, 32'd0);
      saved = done_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_after_reset", 32'(done_cnt), 32'(saved));
      do_mul(8'd5, 8'd6, 1'b1);

      // Corners
      do_mul(8'h80, 8'h80, 1'b1);
      do_mul(8'h80, 8'h7F, 1'b1);
      do_mul(8'h00, 8'hFF, 1'b1);
      do_mul(8'hFF, 8'hFF, 1'b1);

      // Back-to-back with start held high
      ba[0] = 8'd12;  bb[0] = 8'd11;
      ba[1] = 8'hF6;  bb[1] = 8'd25;
      ba[2] = 8'd100; bb[2] = 8'h9C;
      ba[3] = 8'h81;  bb[3] = 8'h81;
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic signed [15:0] e;
         int n;
         e = $signed(ba[k]) * $signed(bb[k]);
         eq.push_back(e);
         mcand  = ba[k];
         mplier = bb[k];
         @(posedge clk);
         #1;
         mcand  = 8'h55;
         mplier = 8'hAA;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (busy && n < 20);
      end
      start = 1'b0;

      // Start while busy is ignored
      @(negedge clk);
      wait_idle();
      saved = done_cnt;
      eq.push_back(16'hFF74);   // 20 x -7 = -140
      start = 1'b1; mcand = 8'd20; mplier = 8'hF9;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1; mcand = 8'd99; mplier = 8'd99;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (12) @(negedge clk);
      chk("one_done_when_busy_start", 32'(done_cnt - saved), 32'd1);

      // Random pairs
      for (int i = 0; i < 1000; i++) begin
         do_mul(8'($urandom), 8'($urandom), 1'b0);
      end

      repeat (10) @(negedge clk);
      chk("queue_drained", 32'(eq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
